ps2_spectrum_matrix: RTL and testbench

Receives a PS/2 keyboard byte stream (scan-code set 2) and maintains a ZX Spectrum 8x5 key matrix. It answers the CPU's ULA keyboard read (IN from port FE) using the address high byte as the active-low row select. It sits upstream of the CPU data-in mux, and its ps2 pins connect to the USB/PS2 pads. It also gives the diagnostics LEDs/LCD a decoded-byte strobe and a parity-error indication.

---
 rtl/ps2_spectrum_matrix.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_ps2_spectrum_matrix.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_spectrum_matrix.sv
// ps2_spectrum_matrix: PS/2 set-2 receiver maintaining a ZX Spectrum
// 8x5 key matrix, read back through the ULA port FE row select.
module ps2_spectrum_matrix #(
  parameter int c_filter_len = 8,
  parameter int c_timeout    = 25000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] addr_hi,
  output logic [4:0] kbd_data,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       parity_err,
  output logic       reset_req
);

  localparam int FW = $clog2(c_filter_len + 1);
  localparam int TW = $clog2(c_timeout + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } rx_state_e;

  logic [1:0]    csync_q, dsync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          clk_edge, fall, din;

  rx_state_e     state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    code_q, code_d;
  logic          strobe_q, strobe_d;
  logic          perr_q, perr_d;

  logic [7:0][4:0] mat_q, mat_d, eff;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          bksp_q, bksp_d, left_q, left_d;
  logic          down_q, down_d, up_q, up_d;
  logic          right_q, right_d, rst_q, rst_d;
  logic [6:0]    m;
  logic [4:0]    kbd_d;

  // Map entry: {hit, row[2:0], col[2:0]}
  function automatic logic [6:0] map_key(input logic [7:0] c);
    logic [6:0] r;
    r = '0;
    case (c)
      8'h12, 8'h59: r = 7'h40;
      8'h1A: r = 7'h41;
      8'h22: r = 7'h42;
      8'h21: r = 7'h43;
      8'h2A: r = 7'h44;
      8'h1C: r = 7'h48;
      8'h1B: r = 7'h49;
      8'h23: r = 7'h4A;
      8'h2B: r = 7'h4B;
      8'h34: r = 7'h4C;
      8'h15: r = 7'h50;
      8'h1D: r = 7'h51;
      8'h24: r = 7'h52;
      8'h2D: r = 7'h53;
      8'h2C: r = 7'h54;
      8'h16: r = 7'h58;
      8'h1E: r = 7'h59;
      8'h26: r = 7'h5A;
      8'h25: r = 7'h5B;
      8'h2E: r = 7'h5C;
      8'h45: r = 7'h60;
      8'h46: r = 7'h61;
      8'h3E: r = 7'h62;
      8'h3D: r = 7'h63;
      8'h36: r = 7'h64;
      8'h4D: r = 7'h68;
      8'h44: r = 7'h69;
      8'h43: r = 7'h6A;
      8'h3C: r = 7'h6B;
      8'h35: r = 7'h6C;
      8'h5A: r = 7'h70;
      8'h4B: r = 7'h71;
      8'h42: r = 7'h72;
      8'h3B: r = 7'h73;
      8'h33: r = 7'h74;
      8'h29: r = 7'h78;
      8'h14: r = 7'h79;
      8'h3A: r = 7'h7A;
      8'h31: r = 7'h7B;
      8'h32: r = 7'h7C;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] map_ext(input logic [7:0] c);
    logic [6:0] r;
    r = '0;
    case (c)
      8'h14: r = 7'h79;
      8'h5A: r = 7'h70;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign din = dsync_q[1];

  always_comb begin
    filt_d   = filt_q;
    fcnt_d   = '0;
    clk_edge = 1'b0;
    fall     = 1'b0;
    if (csync_q[1] != filt_q) begin
      if (fcnt_q == FW'(c_filter_len - 1)) begin
        filt_d   = ~filt_q;
        clk_edge = 1'b1;
        fall     = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    code_d   = code_q;
    strobe_d = 1'b0;
    perr_d   = 1'b0;
    if (clk_edge || state_q == IDLE) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
    // An edge clears the timeout, so it wins over an abort
    if (!clk_edge && state_q != IDLE &&
        tcnt_q >= TW'(c_timeout - 1)) begin
      state_d = IDLE;
    end
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!din) begin
            state_d = SHIFT;
            bcnt_d  = '0;
          end
        end
        SHIFT: begin
          sh_d   = {din, sh_q[7:1]};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          if (din && (^sh_q ^ par_q)) begin
            code_d   = sh_q;
            strobe_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mat_d   = mat_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    bksp_d  = bksp_q;
    left_d  = left_q;
    down_d  = down_q;
    up_d    = up_q;
    right_d = right_q;
    rst_d   = rst_q;
    m = ext_q ? map_ext(code_q) : map_key(code_q);
    if (strobe_q) begin
      if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!ext_q) begin
          if (code_q == 8'h66) bksp_d = ~brk_q;
          if (code_q == 8'h07) rst_d = ~brk_q;
        end else begin
          case (code_q)
            8'h6B: left_d = ~brk_q;
            8'h72: down_d = ~brk_q;
            8'h75: up_d = ~brk_q;
            8'h74: right_d = ~brk_q;
            default: ;
          endcase
        end
        if (m[6]) mat_d[m[5:3]][m[2:0]] = ~brk_q;
      end
    end
  end

  // Composites press CAPS plus a digit on top of the direct bits
  always_comb begin
    logic col;
    eff = mat_q;
    eff[0][0] = mat_q[0][0] | bksp_q | left_q |
                down_q | up_q | right_q;
    eff[4][0] = mat_q[4][0] | bksp_q;
    eff[3][4] = mat_q[3][4] | left_q;
    eff[4][4] = mat_q[4][4] | down_q;
    eff[4][3] = mat_q[4][3] | up_q;
    eff[4][2] = mat_q[4][2] | right_q;
    kbd_d = '1;
    for (int c = 0; c < 5; c++) begin
      col = 1'b0;
      for (int r = 0; r < 8; r++) begin
        if (!addr_hi[r]) col = col | eff[r][c];
      end
      kbd_d[c] = ~col;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csync_q  <= 2'b11;
      dsync_q  <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= IDLE;
      bcnt_q   <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      code_q   <= '0;
      strobe_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      csync_q  <= {csync_q[0], ps2_clk};
      dsync_q  <= {dsync_q[0], ps2_data};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mat_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      bksp_q  <= 1'b0;
      left_q  <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      right_q <= 1'b0;
      rst_q   <= 1'b0;
    end else begin
      mat_q   <= mat_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      bksp_q  <= bksp_d;
      left_q  <= left_d;
      down_q  <= down_d;
      up_q    <= up_d;
      right_q <= right_d;
      rst_q   <= rst_d;
    end
  end

  assign kbd_data   = kbd_d;
  assign key_strobe = strobe_q;
  assign key_code   = code_q;
  assign parity_err = perr_q;
  assign reset_req  = rst_q;

endmodule

// File: tb/tb_ps2_spectrum_matrix.sv
// tb_ps2_spectrum_matrix: directed PS/2 frames with a scoreboard
// of expected strobe/parity events plus matrix readback checks.
`timescale 1ns/1ps
module tb_ps2_spectrum_matrix;

  localparam int HP = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] addr_hi = 8'hFF;
  logic [4:0] kbd_data;
  logic       key_strobe;
  logic [7:0] key_code;
  logic       parity_err;
  logic       reset_req;

  typedef struct {
    bit         perr;
    logic [7:0] code;
  } ev_t;

  ev_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;

  ps2_spectrum_matrix #(
    .c_filter_len(8),
    .c_timeout(400)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .addr_hi(addr_hi),
    .kbd_data(kbd_data),
    .key_strobe(key_strobe),
    .key_code(key_code),
    .parity_err(parity_err),
    .reset_req(reset_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && (key_strobe || parity_err)) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event strobe=%0b perr=%0b code=%h",
                 key_strobe, parity_err, key_code);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.perr) begin
          if (!parity_err || key_strobe) begin
            n_fail++;
            $display("FAIL perr_event got strobe=%0b perr=%0b want perr",
                     key_strobe, parity_err);
          end
        end else if (!key_strobe || parity_err || key_code !== e.code) begin
          n_fail++;
          $display("FAIL strobe_event got code=%h perr=%0b want code=%h",
                   key_code, parity_err, e.code);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic kbd(input string nm, input logic [7:0] a,
                     input logic [4:0] exp);
    @(negedge clk);
    addr_hi = a;
    #1;
    chk(nm, {3'b0, kbd_data}, {3'b0, exp});
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic gap();
    repeat (2 * HP) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string nm);
    gap();
    chk(nm, 8'(sb.size()), 8'd0);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par,
                       input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(~bad_stop);
  endtask

  task automatic key(input logic [7:0] b);
    ev_t e;
    e.perr = 1'b0;
    e.code = b;
    sb.push_back(e);
    frame(b, 1'b0, 1'b0);
  endtask

  initial begin
    ev_t e;
    repeat (5) @(negedge clk);
    addr_hi = 8'h00;
    #1;
    chk("rst_kbd", {3'b0, kbd_data}, 8'h1F);
    chk("rst_strobe", {7'b0, key_strobe}, 8'h00);
    chk("rst_code", key_code, 8'h00);
    chk("rst_perr", {7'b0, parity_err}, 8'h00);
    chk("rst_rreq", {7'b0, reset_req}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    key(8'h1C);
    drain("drain_1c");
    kbd("1c_fd", 8'hFD, 5'h1E);
    kbd("1c_ff", 8'hFF, 5'h1F);
    chk("1c_code", key_code, 8'h1C);

    key(8'hF0);
    key(8'h1C);
    drain("drain_brk1c");
    kbd("brk1c_00", 8'h00, 5'h1F);
    chk("brk1c_code", key_code, 8'h1C);

    e.perr = 1'b1;
    e.code = 8'h00;
    sb.push_back(e);
    frame(8'h29, 1'b1, 1'b0);
    drain("drain_badpar");
    kbd("badpar_7f", 8'h7F, 5'h1F);
    chk("badpar_code", key_code, 8'h1C);
    sb.push_back(e);
    frame(8'h29, 1'b0, 1'b1);
    drain("drain_badstop");
    kbd("badstop_7f", 8'h7F, 5'h1F);

    key(8'h12);
    key(8'h66);
    drain("drain_bksp");
    kbd("bksp_fe", 8'hFE, 5'h1E);
    kbd("bksp_ef", 8'hEF, 5'h1E);
    key(8'hF0);
    key(8'h66);
    drain("drain_bksp_rel");
    kbd("bksprel_fe", 8'hFE, 5'h1E);
    kbd("bksprel_ef", 8'hEF, 5'h1F);
    key(8'hF0);
    key(8'h12);
    drain("drain_shift_rel");
    kbd("shiftrel_fe", 8'hFE, 5'h1F);

    key(8'hE0);
    key(8'h6B);
    drain("drain_left");
    kbd("left_fe", 8'hFE, 5'h1E);
    kbd("left_f7", 8'hF7, 5'h0F);
    key(8'hF0);
    key(8'h6B);
    drain("drain_f06b");
    kbd("f06b_fe", 8'hFE, 5'h1E);
    kbd("f06b_f7", 8'hF7, 5'h0F);
    key(8'hE0);
    key(8'hF0);
    key(8'h6B);
    drain("drain_leftrel");
    kbd("leftrel_00", 8'h00, 5'h1F);

    key(8'h07);
    drain("drain_f12");
    chk("f12_rreq", {7'b0, reset_req}, 8'h01);
    key(8'hF0);
    key(8'h07);
    drain("drain_f12rel");
    chk("f12rel_rreq", {7'b0, reset_req}, 8'h00);

    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (600) @(negedge clk);
    key(8'h29);
    drain("drain_tmo");
    chk("tmo_code", key_code, 8'h29);
    kbd("tmo_7f", 8'h7F, 5'h1E);

    ps2_data = 1'b0;
    repeat (HP) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
    key(8'hF0);
    key(8'h29);
    drain("drain_glitch");
    kbd("glitch_7f", 8'h7F, 5'h1E | 5'h01);

    key(8'h1C);
    drain("drain_pre_rst");
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    addr_hi = 8'h00;
    #1;
    chk("midrst_kbd", {3'b0, kbd_data}, 8'h1F);
    chk("midrst_code", key_code, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    key(8'h1A);
    drain("drain_post_rst");
    kbd("postrst_fe", 8'hFE, 5'h1D);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
